rprelu_stream: RTL and testbench



---
 rtl/rprelu_stream_pkg.sv | 26 ++
 rtl/rprelu_stream_if.sv | 23 ++
 rtl/rprelu_stream_lane.sv | 74 +++++++
 rtl/rprelu_stream.sv | 113 +++++++++++
 tb/tb_rprelu_stream.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rprelu_stream_pkg.sv
// rtl/rprelu_stream_pkg.sv - shared types, mode constants and saturation helper for rprelu_stream
package rprelu_pkg;
    localparam int DATA_W = 16;
    localparam int PARA_W = 16;
    localparam int WIDE_W = 40;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_CALC = 1'b1;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [PARA_W-1:0] para_t;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic data_t sat_data(input wide_t v);
        wide_t hi;
        wide_t lo;
        hi = wide_t'({1'b0, {(DATA_W-1){1'b1}}});
        lo = -hi - wide_t'(1);
        if (v > hi)
            sat_data = data_t'(hi);
        else if (v < lo)
            sat_data = data_t'(lo);
        else
            sat_data = data_t'(v);
    endfunction
endpackage

// File: rtl/rprelu_stream_if.sv
// rtl/rprelu_stream_if.sv - input/output beat handshake bundle for rprelu_stream
interface rprelu_stream_if #(
    parameter int LANES      = 16,
    parameter int DATA_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*DATA_WIDTH-1:0] out_data;
    logic                        out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rprelu_stream_lane.sv
// rtl/rprelu_stream_lane.sv - one lane of the 3-stage RPReLU datapath, all stages advance on en_i
module rprelu_lane
    import rprelu_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    input  logic  byp_i,
    input  data_t x_i,
    input  para_t beta_i,
    input  para_t gamma_i,
    input  para_t zeta_i,
    output data_t y_o
);
    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = PARA_W + DIFF_W;

    typedef logic signed [DIFF_W-1:0] diff_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    diff_t s1_d_d, s1_d_q, s2_d_q;
    logic  s1_pos_d, s1_pos_q, s2_pos_q;
    logic  s1_byp_q, s2_byp_q;
    para_t s1_beta_q, s1_zeta_q, s2_zeta_q;
    data_t s1_x_q, s2_x_q;
    prod_t s2_p_d, s2_p_q;
    wide_t sum;
    data_t y_d, y_q;

    // equality goes to the slope branch, where d == 0 leaves just zeta
    always_comb begin
        s1_d_d   = diff_t'(x_i) - diff_t'(gamma_i);
        s1_pos_d = x_i > gamma_i;
        s2_p_d   = (prod_t'(s1_beta_q) * prod_t'(s1_d_q)) >>> FRAC_BITS;
        sum      = (s2_pos_q ? wide_t'(s2_d_q) : wide_t'(s2_p_q)) + wide_t'(s2_zeta_q);
        y_d      = s2_byp_q ? s2_x_q : sat_data(sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_d_q    <= '0;
            s1_pos_q  <= 1'b0;
            s1_byp_q  <= 1'b0;
            s1_beta_q <= '0;
            s1_zeta_q <= '0;
            s1_x_q    <= '0;
            s2_d_q    <= '0;
            s2_p_q    <= '0;
            s2_pos_q  <= 1'b0;
            s2_byp_q  <= 1'b0;
            s2_zeta_q <= '0;
            s2_x_q    <= '0;
            y_q       <= '0;
        end else if (en_i) begin
            s1_d_q    <= s1_d_d;
            s1_pos_q  <= s1_pos_d;
            s1_byp_q  <= byp_i;
            s1_beta_q <= beta_i;
            s1_zeta_q <= zeta_i;
            s1_x_q    <= x_i;
            s2_d_q    <= s1_d_q;
            s2_p_q    <= s2_p_d;
            s2_pos_q  <= s1_pos_q;
            s2_byp_q  <= s1_byp_q;
            s2_zeta_q <= s1_zeta_q;
            s2_x_q    <= s1_x_q;
            y_q       <= y_d;
        end
    end

    assign y_o = y_q;
endmodule

// File: rtl/rprelu_stream.sv
// rtl/rprelu_stream.sv - RPReLU stream stage: parameter banks, row counter, handshake and lane array
module rprelu_stream
    import rprelu_pkg::*;
#(
    parameter int CHANNEL_NUM = 256,
    parameter int LANES       = 16,
    parameter int DATA_WIDTH  = DATA_W,
    parameter int PARA_WIDTH  = PARA_W,
    parameter int FRAC_BITS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mode,
    input  logic                           bypass,
    input  logic                           para_we,
    input  logic [$clog2(CHANNEL_NUM)-1:0] para_addr,
    input  logic [PARA_WIDTH-1:0]          para_beta,
    input  logic [PARA_WIDTH-1:0]          para_gamma,
    input  logic [PARA_WIDTH-1:0]          para_zeta,
    rprelu_stream_if.slave                 s
);
    localparam int ROWS  = CHANNEL_NUM / LANES;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    para_t beta_q  [LANES][ROWS];
    para_t gamma_q [LANES][ROWS];
    para_t zeta_q  [LANES][ROWS];

    logic [ROW_W-1:0] row_d, row_q;
    logic v1_q, v2_q, out_valid_q;
    logic l1_q, l2_q, out_last_q;
    logic en, in_ready_w, in_fire, row_is_last;
    logic [LANES*DATA_WIDTH-1:0] out_data_w;

    assign en          = !out_valid_q || s.out_ready;
    assign in_ready_w  = en && (mode == MODE_CALC);
    assign in_fire     = s.in_valid && in_ready_w;
    assign row_is_last = (row_q == ROW_W'(ROWS - 1));

    // leaving CALC mode throws away any partial pixel
    always_comb begin
        row_d = row_q;
        if (mode == MODE_LOAD)
            row_d = '0;
        else if (in_fire)
            row_d = row_is_last ? '0 : row_q + ROW_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) begin
                for (int r = 0; r < ROWS; r++) begin
                    beta_q[k][r]  <= '0;
                    gamma_q[k][r] <= '0;
                    zeta_q[k][r]  <= '0;
                end
            end
        end else if (para_we && (mode == MODE_LOAD)) begin
            for (int k = 0; k < LANES; k++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (int'(para_addr) == r * LANES + k) begin
                        beta_q[k][r]  <= para_beta;
                        gamma_q[k][r] <= para_gamma;
                        zeta_q[k][r]  <= para_zeta;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            l1_q        <= 1'b0;
            l2_q        <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            row_q <= row_d;
            if (en) begin
                v1_q        <= in_fire;
                l1_q        <= in_fire && row_is_last;
                v2_q        <= v1_q;
                l2_q        <= l1_q;
                out_valid_q <= v2_q;
                out_last_q  <= l2_q;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        rprelu_lane #(
            .FRAC_BITS(FRAC_BITS)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en_i   (en),
            .byp_i  (bypass),
            .x_i    (s.in_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .beta_i (beta_q[k][row_q]),
            .gamma_i(gamma_q[k][row_q]),
            .zeta_i (zeta_q[k][row_q]),
            .y_o    (out_data_w[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign s.in_ready  = in_ready_w;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_w;
    assign s.out_last  = out_last_q;
endmodule

// File: tb/tb_rprelu_stream.sv
// tb/tb_rprelu_stream.sv - self-checking bench for rprelu_stream
module tb_rprelu_stream;
    localparam int CH   = 256;
    localparam int LN   = 16;
    localparam int DW   = 16;
    localparam int ROWS = CH / LN;
    localparam int BW   = LN * DW;

    logic          clk = 1'b0;
    logic          rst, mode, bypass, para_we;
    logic [7:0]    para_addr;
    logic [15:0]   para_beta, para_gamma, para_zeta;

    rprelu_stream_if #(.LANES(LN), .DATA_WIDTH(DW)) bus ();

    rprelu_stream #(
        .CHANNEL_NUM(CH), .LANES(LN), .DATA_WIDTH(DW), .PARA_WIDTH(16), .FRAC_BITS(8)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .bypass(bypass), .para_we(para_we),
        .para_addr(para_addr), .para_beta(para_beta), .para_gamma(para_gamma),
        .para_zeta(para_zeta), .s(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_beta [CH];
    logic [15:0] m_gamma[CH];
    logic [15:0] m_zeta [CH];
    int          row_m;

    typedef struct { logic [BW-1:0] data; logic last; } beat_t;
    beat_t       exp_q[$];
    beat_t       e_m;
    logic [15:0] log_d[$];
    logic        log_l[$];
    logic        hold_v;
    logic [BW-1:0] hold_d;
    logic        hold_l;

    typedef struct {
        string       name;
        logic [15:0] beta, gamma, zeta, x;
        logic        byp;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // plain-integer model: floor division for the Q8 slope, clamp at the end
    function automatic logic [15:0] ref_lane(input int x, input int b, input int g, input int z, input logic byp);
        longint d, p, y;
        if (byp) begin
            y = longint'(x);
            return y[15:0];
        end
        d = longint'(x) - longint'(g);
        if (x > g) begin
            y = d + longint'(z);
        end else begin
            p = longint'(b) * d;
            p = (p >= 0) ? p / 256 : -((-p + 255) / 256);
            y = p + longint'(z);
        end
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y[15:0];
    endfunction

    function automatic logic [BW-1:0] rand_data();
        logic [BW-1:0] v;
        for (int i = 0; i < LN; i++) v[i*DW +: DW] = 16'($urandom);
        return v;
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_q.delete();
            row_m  = 0;
            hold_v = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_beta[c] = '0; m_gamma[c] = '0; m_zeta[c] = '0;
            end
        end else begin
            if (bus.out_valid) begin
                if (hold_v) begin
                    check("hold_data", bus.out_data, hold_d);
                    check("hold_last", BW'(bus.out_last), BW'(hold_l));
                end
                if (bus.out_ready) begin
                    hold_v = 1'b0;
                    check("beat_expected", BW'(exp_q.size() > 0), BW'(1));
                    if (exp_q.size() > 0) begin
                        e_m = exp_q.pop_front();
                        check("out_data", bus.out_data, e_m.data);
                        check("out_last", BW'(bus.out_last), BW'(e_m.last));
                    end
                    log_d.push_back(bus.out_data[15:0]);
                    log_l.push_back(bus.out_last);
                end else begin
                    check("in_ready_stall", BW'(bus.in_ready), BW'(0));
                    hold_v = 1'b1;
                    hold_d = bus.out_data;
                    hold_l = bus.out_last;
                end
            end else begin
                hold_v = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int k = 0; k < LN; k++) begin
                    int c;
                    c = row_m * LN + k;
                    e_m.data[k*DW +: DW] = ref_lane(sx(bus.in_data[k*DW +: DW]), sx(m_beta[c]),
                                                    sx(m_gamma[c]), sx(m_zeta[c]), bypass);
                end
                e_m.last = (row_m == ROWS - 1);
                exp_q.push_back(e_m);
                row_m = (row_m + 1) % ROWS;
            end
            if (mode == 1'b0) row_m = 0;
            if (para_we && mode == 1'b0) begin
                m_beta[para_addr]  = para_beta;
                m_gamma[para_addr] = para_gamma;
                m_zeta[para_addr]  = para_zeta;
            end
        end
    end

    task automatic send_beat(input logic [BW-1:0] d, input logic byp);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bypass       = byp;
        #1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accepted", BW'(bus.in_ready), BW'(1));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic load_param(input int c, input logic [15:0] b, input logic [15:0] g, input logic [15:0] z);
        @(negedge clk);
        mode = 1'b0; para_we = 1'b1; para_addr = 8'(c);
        para_beta = b; para_gamma = g; para_zeta = z;
        @(negedge clk);
        para_we = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.out_valid); i++) @(negedge clk);
        check("drained", BW'(exp_q.size()), BW'(0));
    endtask

    function automatic int count_last(input int base);
        int n = 0;
        for (int i = base; i < log_l.size(); i++) if (log_l[i]) n++;
        return n;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] d;
        int base, n;
        logic done;

        tbl[0] = '{"pos",      16'h0040, 16'h0100, 16'h0080, 16'h0300, 1'b0, 16'h0280};
        tbl[1] = '{"neg",      16'h0040, 16'h0000, 16'h0000, 16'hFF00, 1'b0, 16'hFFC0};
        tbl[2] = '{"equal",    16'h0040, 16'h0100, 16'h0011, 16'h0100, 1'b0, 16'h0011};
        tbl[3] = '{"sat_hi",   16'h0040, 16'h8000, 16'h0000, 16'h7F00, 1'b0, 16'h7FFF};
        tbl[4] = '{"sat_lo",   16'h7FFF, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 16'h8000};
        tbl[5] = '{"bypass",   16'h0040, 16'h0100, 16'h0080, 16'h1234, 1'b1, 16'h1234};
        tbl[6] = '{"floor",    16'h0040, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF};
        tbl[7] = '{"frac_mul", 16'h0180, 16'h0010, 16'hFFF0, 16'hFF10, 1'b0, 16'hFE70};

        rst = 1'b1; mode = 1'b0; bypass = 1'b0; para_we = 1'b0; para_addr = '0;
        para_beta = '0; para_gamma = '0; para_zeta = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", BW'(bus.out_valid), BW'(0));
        check("rst_out_data",  bus.out_data, BW'(0));
        check("rst_out_last",  BW'(bus.out_last), BW'(0));
        rst = 1'b0; mode = 1'b1;
        #1 check("rst_in_ready_calc", BW'(bus.in_ready), BW'(1));
        mode = 1'b0;
        #1 check("rst_in_ready_load", BW'(bus.in_ready), BW'(0));

        for (int i = 0; i < 8; i++) begin
            load_param(0, tbl[i].beta, tbl[i].gamma, tbl[i].zeta);
            mode = 1'b1;
            d = rand_data();
            d[15:0] = tbl[i].x;
            send_beat(d, tbl[i].byp);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bypass = 1'b0;
            n = 1;
            while (!bus.out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            check({tbl[i].name, "_latency"}, BW'(n), BW'(3));
            check({tbl[i].name, "_lane0"}, BW'(bus.out_data[15:0]), BW'(tbl[i].exp));
        end
        drain();

        base = log_d.size();
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(rand_data(), 1'b0);
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", BW'(log_d.size() - base), BW'(8));

        @(negedge clk) mode = 1'b0;
        @(negedge clk) mode = 1'b1;
        base = log_d.size();
        for (int i = 0; i < 40; i++) send_beat(rand_data(), 1'b0);
        idle();
        drain();
        check("last40_count", BW'(count_last(base)), BW'(2));
        check("last40_at16", BW'(log_l[base + 15]), BW'(1));
        check("last40_at32", BW'(log_l[base + 31]), BW'(1));
        @(negedge clk) mode = 1'b0;
        @(negedge clk) mode = 1'b1;
        base = log_d.size();
        for (int i = 0; i < 16; i++) send_beat(rand_data(), 1'b0);
        idle();
        drain();
        check("last16_count", BW'(count_last(base)), BW'(1));
        check("last16_at16", BW'(log_l[base + 15]), BW'(1));

        load_param(0, 16'h0100, 16'h0000, 16'h0000);
        mode = 1'b1;
        base = log_d.size();
        d = rand_data();
        d[15:0] = 16'h0010;
        @(negedge clk) bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(d, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0; mode = 1'b0; para_we = 1'b1; para_addr = 8'd0;
        para_beta = 16'h0100; para_gamma = 16'h0000; para_zeta = 16'h0100;
        @(negedge clk) para_we = 1'b0;
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b1; mode = 1'b1;
        drain();
        send_beat(d, 1'b0);
        idle();
        drain();
        check("drain_count", BW'(log_d.size() - base), BW'(4));
        for (int i = 0; i < 3; i++) check("drain_old_zeta", BW'(log_d[base + i]), BW'(16'h0010));
        check("new_zeta", BW'(log_d[base + 3]), BW'(16'h0110));

        for (int i = 0; i < 3; i++) send_beat(rand_data(), 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        #1 check("midrst_out_valid", BW'(bus.out_valid), BW'(0));
        rst = 1'b0;
        base = log_d.size();
        for (int i = 0; i < 16; i++) send_beat(rand_data(), 1'b0);
        idle();
        drain();
        check("midrst_count", BW'(log_d.size() - base), BW'(16));
        check("midrst_last", BW'(log_l[base + 15]), BW'(1));

        @(negedge clk) mode = 1'b0;
        for (int c = 0; c < CH; c++) begin
            @(negedge clk);
            para_we = 1'b1; para_addr = 8'(c);
            para_beta = 16'($urandom); para_gamma = 16'($urandom); para_zeta = 16'($urandom);
        end
        @(negedge clk) para_we = 1'b0;
        mode = 1'b1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) idle();
                    send_beat(rand_data(), ($urandom_range(0, 4) == 0));
                end
                idle();
                bypass = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
